fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 8-bit processor. Holds the program counter, drives the instruction-memory address bus, waits a fixed number of clocks for the asynchronous memory read to settle, and latches the returned byte into an instruction register. The instruction register is handed to decode with a valid/stall handshake. The block accepts taken-branch redirects from execute.

## Interface

Parameters:
- ADDR_W, 8, PC / address-bus width
- DATA_W, 8, instruction width
- RESET_PC, 8'h00, PC value after reset
- WAIT_CYCLES, 2, extra clocks between an address change and sampling DATABUS; range 0..7

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLK  in  1  rising-edge clock
- RSTN  in  1  asynchronous active-low reset
- ABUS  out  ADDR_W  instruction-memory address, always equals PC register
- DATABUS  in  DATA_W  instruction-memory read data (fetch never drives it)
- STALL  in  1  decode cannot accept IR this cycle
- BR_TAKEN  in  1  redirect request, one-cycle pulse
- BR_TARGET  in  ADDR_W  redirect address, valid when BR_TAKEN=1
- IR  out  DATA_W  latched instruction
- IR_PC  out  ADDR_W  address IR was fetched from
- IR_VALID  out  1  IR holds an unconsumed instruction

## Operation

- State registers: PC, wait counter CNT (3 bits), FSM state, IR, IR_PC, IR_VALID.
- FSM states: BOOT, FETCH, VALID.
  - BOOT: entered on reset. Next edge: FETCH with CNT=WAIT_CYCLES.
  - FETCH: if CNT!=0, CNT decrements. If CNT==0, on the edge: IR<=DATABUS, IR_PC<=PC, IR_VALID<=1, and the FSM moves to VALID.
  - VALID: if STALL=1, all registers hold. If STALL=0, the instruction is consumed on this edge: PC<=PC+1, IR_VALID<=0, CNT<=WAIT_CYCLES, and the FSM moves to FETCH.
- Redirect: BR_TAKEN=1 in any state other than BOOT has top priority over STALL and over capture.
  - On that edge: PC<=BR_TARGET, IR_VALID<=0, CNT<=WAIT_CYCLES, FSM to FETCH.
  - Any in-flight fetch is squashed. IR/IR_PC keep stale contents but are invalid.
- BR_TAKEN during BOOT is ignored.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF+1 wraps to 8'h00 with no flag.
- IR and IR_PC change only on capture. Decode must ignore them when IR_VALID=0.
- Reset asserted mid-operation immediately forces all reset values, whatever the FSM state or counter value.

## Timing

- Reset values: PC=ABUS=RESET_PC, IR=0, IR_PC=0, IR_VALID=0, CNT=WAIT_CYCLES, state BOOT.
- ABUS is a direct register output with no combinational path from any input.
- Fetch latency counts edges from the edge that updates PC to the edge that sets IR_VALID: WAIT_CYCLES+1.
  - First instruction after reset release: WAIT_CYCLES+2 edges (includes BOOT).
- Sustained throughput with STALL=0: one instruction per WAIT_CYCLES+2 clocks.
- IR_VALID falls on the same edge that consumes or squashes the instruction. It never pulses for less than one full cycle.
- DATABUS is sampled only on the capture edge. It must be stable for WAIT_CYCLES+1 clock periods after ABUS changes; the clock period must exceed the memory access delay divided by (WAIT_CYCLES+1).
- Simultaneous BR_TAKEN and capture: the redirect wins and nothing is captured.
- Simultaneous BR_TAKEN and STALL: the redirect wins.

## Structure

- Shared package cpu_pkg holds:
  - ADDR_W and DATA_W defaults.
  - FSM state encoding constants ST_BOOT=2'd0, ST_FETCH=2'd1, ST_VALID=2'd2.
  - The NOP opcode, used by decode when IR_VALID=0.
- One sub-module, fetch_wait_counter: a loadable 3-bit down-counter with a zero flag. Its inputs are load, load value and decrement enable.
- PC register, FSM and IR stay in fetch_unit.

## Test plan

- Reset release, RESET_PC=0, WAIT_CYCLES=2, memory[0]=8'hA5 -> ABUS=0 throughout. IR_VALID rises 4 edges after release with IR=8'hA5, IR_PC=0.
- Streaming, STALL=0, memory[0..3]=11,22,33,44 -> IR sequence 11,22,33,44 with IR_PC 0..3. IR_VALID is high one cycle in every 4.
- STALL held 5 cycles while IR=8'h22 valid -> IR, IR_PC=1, ABUS=1 and IR_VALID all frozen. Release -> ABUS=2 on the next edge.
- BR_TAKEN with BR_TARGET=8'h80 in FETCH (CNT=1), with STALL=1 on the same edge -> no capture, ABUS=8'h80 next edge. Next IR_VALID carries memory[8'h80] and IR_PC=8'h80.
- Wrap: BR_TARGET=8'hFF, STALL=0 -> IR_PC=8'hFF, then the next ABUS is 8'h00 and IR_PC=8'h00.
- RSTN pulsed low while in VALID with IR_VALID=1 -> IR_VALID=0, ABUS=RESET_PC immediately, before any clock edge. Normal fetch resumes after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: default bus widths,
// fetch FSM state encoding and the opcode decode substitutes for an invalid IR.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    localparam logic [7:0] OP_NOP = 8'h00;

endpackage

// File: rtl/fetch_wait_counter.sv
// Loadable 3-bit down-counter timing the instruction-memory access window.
// Saturates at zero; zero_o flags the capture cycle.
module fetch_wait_counter #(
    parameter logic [2:0] RESET_VAL = '0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, fixed-latency memory wait, IR latch with
// valid/stall handshake to decode, and taken-branch redirect from execute.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    output logic [ADDR_W-1:0] ABUS,
    input  logic [DATA_W-1:0] DATABUS,
    input  logic              STALL,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_TARGET,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] IR_PC,
    output logic              IR_VALID
);

    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              cnt_load, cnt_dec, cnt_zero;

    fetch_wait_counter #(
        .RESET_VAL(WAIT_LD)
    ) u_wait (
        .clk_i      (CLK),
        .rst_ni     (RSTN),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        // A redirect outranks both capture and stall; IR/IR_PC are left stale.
        if (state_q != ST_BOOT && BR_TAKEN) begin
            pc_d       = BR_TARGET;
            ir_valid_d = 1'b0;
            cnt_load   = 1'b1;
            state_d    = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    cnt_load = 1'b1;
                    state_d  = ST_FETCH;
                end
                ST_FETCH: begin
                    if (cnt_zero) begin
                        ir_d       = DATABUS;
                        ir_pc_d    = pc_q;
                        ir_valid_d = 1'b1;
                        state_d    = ST_VALID;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_VALID: begin
                    if (!STALL) begin
                        pc_d       = pc_q + ADDR_W'(1);
                        ir_valid_d = 1'b0;
                        cnt_load   = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign ABUS     = pc_q;
    assign IR       = ir_q;
    assign IR_PC    = ir_pc_q;
    assign IR_VALID = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-edge vector table plus hand-written
// reset-latency and asynchronous-reset sequences against a behavioural memory.
module tb_fetch_unit;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic [7:0] ABUS;
    logic [7:0] DATABUS;
    logic       STALL = 1'b0;
    logic       BR_TAKEN = 1'b0;
    logic [7:0] BR_TARGET = '0;
    logic [7:0] IR;
    logic [7:0] IR_PC;
    logic       IR_VALID;

    logic [7:0] mem [256];
    assign DATABUS = mem[ABUS];

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .RESET_PC    (8'h00),
        .WAIT_CYCLES (2)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .ABUS      (ABUS),
        .DATABUS   (DATABUS),
        .STALL     (STALL),
        .BR_TAKEN  (BR_TAKEN),
        .BR_TARGET (BR_TARGET),
        .IR        (IR),
        .IR_PC     (IR_PC),
        .IR_VALID  (IR_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       stall;
        logic       br;
        logic [7:0] tgt;
        logic [7:0] abus;
        logic       v;
        logic [7:0] ir;
        logic [7:0] pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic b, logic [7:0] t,
                                logic [7:0] a, logic v, logic [7:0] i, logic [7:0] p);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.abus = a; r.v = v; r.ir = i; r.pc = p;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_abus", ABUS, 8'h00);
        chk("rst_irv", IR_VALID, 0);
        chk("rst_ir", IR, 8'h00);
        chk("rst_irpc", IR_PC, 8'h00);
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    // Counts edges after release until IR_VALID rises; ABUS must stay at RESET_PC.
    task automatic first_fetch(input string tag, input logic [7:0] exp_ir);
        int n;
        n = 0;
        while (n < 10) begin
            @(posedge CLK); #1;
            n++;
            chk({tag, "_abus"}, ABUS, 8'h00);
            if (IR_VALID) break;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_ir"}, IR, exp_ir);
        chk({tag, "_irpc"}, IR_PC, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

        // Reset release and first-fetch latency.
        mem[0] = 8'hA5;
        do_reset();
        first_fetch("boot", 8'hA5);

        // Per-edge table from a fresh reset release.
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[8'h80] = 8'hC3; mem[8'hFF] = 8'hEE;

        tbl.push_back(mk(0,1,8'h55, 8'h00,0,8'h00,8'h00)); // branch in BOOT ignored
        tbl.push_back(mk(0,0,0, 8'h00,0,8'h00,8'h00));
        tbl.push_back(mk(0,0,0, 8'h00,0,8'h00,8'h00));
        tbl.push_back(mk(0,0,0, 8'h00,1,8'h11,8'h00));
        tbl.push_back(mk(0,0,0, 8'h01,0,8'h11,8'h00));
        tbl.push_back(mk(0,0,0, 8'h01,0,8'h11,8'h00));
        tbl.push_back(mk(0,0,0, 8'h01,0,8'h11,8'h00));
        tbl.push_back(mk(0,0,0, 8'h01,1,8'h22,8'h01));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1,0,0, 8'h01,1,8'h22,8'h01)); // stall freezes
        tbl.push_back(mk(0,0,0, 8'h02,0,8'h22,8'h01));
        tbl.push_back(mk(0,0,0, 8'h02,0,8'h22,8'h01));
        tbl.push_back(mk(0,0,0, 8'h02,0,8'h22,8'h01));
        tbl.push_back(mk(0,0,0, 8'h02,1,8'h33,8'h02));
        tbl.push_back(mk(0,0,0, 8'h03,0,8'h33,8'h02));
        tbl.push_back(mk(0,0,0, 8'h03,0,8'h33,8'h02));
        tbl.push_back(mk(1,1,8'h80, 8'h80,0,8'h33,8'h02)); // redirect in FETCH, CNT=1
        tbl.push_back(mk(0,0,0, 8'h80,0,8'h33,8'h02));
        tbl.push_back(mk(0,0,0, 8'h80,0,8'h33,8'h02));
        tbl.push_back(mk(0,0,0, 8'h80,1,8'hC3,8'h80));
        tbl.push_back(mk(0,1,8'hFF, 8'hFF,0,8'hC3,8'h80)); // redirect beats consume
        tbl.push_back(mk(0,0,0, 8'hFF,0,8'hC3,8'h80));
        tbl.push_back(mk(0,0,0, 8'hFF,0,8'hC3,8'h80));
        tbl.push_back(mk(0,0,0, 8'hFF,1,8'hEE,8'hFF));
        tbl.push_back(mk(0,0,0, 8'h00,0,8'hEE,8'hFF)); // PC wraps
        tbl.push_back(mk(0,0,0, 8'h00,0,8'hEE,8'hFF));
        tbl.push_back(mk(0,0,0, 8'h00,0,8'hEE,8'hFF));
        tbl.push_back(mk(0,0,0, 8'h00,1,8'h11,8'h00));
        tbl.push_back(mk(0,0,0, 8'h01,0,8'h11,8'h00));
        tbl.push_back(mk(0,0,0, 8'h01,0,8'h11,8'h00));
        tbl.push_back(mk(0,0,0, 8'h01,0,8'h11,8'h00));
        tbl.push_back(mk(0,1,8'h03, 8'h03,0,8'h11,8'h00)); // redirect beats capture
        tbl.push_back(mk(0,0,0, 8'h03,0,8'h11,8'h00));
        tbl.push_back(mk(0,0,0, 8'h03,0,8'h11,8'h00));
        tbl.push_back(mk(1,0,0, 8'h03,1,8'h44,8'h03));

        do_reset();
        foreach (tbl[k]) begin
            STALL = tbl[k].stall;
            BR_TAKEN = tbl[k].br;
            BR_TARGET = tbl[k].tgt;
            @(posedge CLK); #1;
            chk($sformatf("v%0d_abus", k), ABUS, tbl[k].abus);
            chk($sformatf("v%0d_irv", k), IR_VALID, tbl[k].v);
            chk($sformatf("v%0d_ir", k), IR, tbl[k].ir);
            chk($sformatf("v%0d_irpc", k), IR_PC, tbl[k].pc);
        end
        BR_TAKEN = 1'b0;

        // Asynchronous reset while VALID (held by STALL), away from any edge.
        chk("pre_arst_irv", IR_VALID, 1);
        #2;
        RSTN = 1'b0;
        #1;
        chk("arst_irv", IR_VALID, 0);
        chk("arst_abus", ABUS, 8'h00);
        chk("arst_ir", IR, 8'h00);
        chk("arst_irpc", IR_PC, 8'h00);
        STALL = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        first_fetch("resume", 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
